// File: rtl/pcie_test_seq_pkg.sv
// Shared types and widths for the PCIe test sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcie_test_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_RUN    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // Width of slot index outputs (covers up to 32 slots).
    localparam int IDX_W = 5;
    // Width of the per-sequence result counters.
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pcie_test_seq_ctrl_if.sv
// Slot-side bus between the sequencer and the test slots.
// Latency: n/a (wires only).
// Backpressure: none; done is a level the sequencer polls while a slot runs.
// Signals: test_en (one-hot slot enable), test_rst (slot reset),
//          test_done / test_fail (per-slot status levels).
interface pcie_test_seq_ctrl_if #(
    parameter int NUM_TESTS = 17
);
    logic [NUM_TESTS-1:0] test_en;
    logic                 test_rst;
    logic [NUM_TESTS-1:0] test_done;
    logic [NUM_TESTS-1:0] test_fail;

    modport master (output test_en, output test_rst, input test_done, input test_fail);
    modport slave  (input test_en, input test_rst, output test_done, output test_fail);
endinterface

// File: rtl/pcie_test_seq_pick.sv
// Finds the lowest set mask bit at or above a scan pointer.
// Latency: combinational.
// Backpressure: none.
// Ports: mask_i (slot mask), ptr_i (scan start), found_o, idx_o (selected slot).
module pcie_test_seq_pick
    import pcie_test_seq_pkg::*;
#(
    parameter int NUM_TESTS = 17
) (
    input  logic [NUM_TESTS-1:0] mask_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     idx_o
);
    // Scan high to low so the last hit written is the lowest qualifying bit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(ptr_i))) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/pcie_test_seq_ctrl.sv
// Runs masked test slots one at a time with timeout and a reset gap between slots.
// Latency: start -> SELECT next cycle; all outputs registered, aligned with FSM state.
// Backpressure: none; start is ignored while a sequence is in progress.
// Ports: clk/rst, start + config (test_mask, stop_on_fail, tmo_limit), slot bus
//        (interface master), status (busy, seq_done, seq_pass, cur_idx,
//        first_err_idx, pass_cnt, fail_cnt, tmo_cnt).
module pcie_test_seq_ctrl
    import pcie_test_seq_pkg::*;
#(
    parameter int NUM_TESTS  = 17,
    parameter int TMO_W      = 32,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] test_mask,
    input  logic                 stop_on_fail,
    input  logic [TMO_W-1:0]     tmo_limit,
    pcie_test_seq_ctrl_if.master slot,
    output logic                 busy,
    output logic                 seq_done,
    output logic                 seq_pass,
    output logic [IDX_W-1:0]     cur_idx,
    output logic [IDX_W-1:0]     first_err_idx,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     tmo_cnt
);
    seq_state_e           state_q, state_d;
    logic [NUM_TESTS-1:0] mask_q, mask_d;
    logic [TMO_W-1:0]     limit_q, limit_d;
    logic                 stop_q, stop_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [IDX_W-1:0]     ferr_q, ferr_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
    logic [TMO_W-1:0]     tctr_q, tctr_d;
    logic [7:0]           gap_q, gap_d;
    logic [NUM_TESTS-1:0] en_q, en_d;
    logic                 trst_q, trst_d;
    logic                 busy_q, busy_d;
    logic                 sdone_q, sdone_d;
    logic                 spass_q, spass_d;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 rec_err;

    pcie_test_seq_pick #(.NUM_TESTS(NUM_TESTS)) u_pick (
        .mask_i  (mask_q),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        limit_d = limit_q;
        stop_d  = stop_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        ferr_d  = ferr_q;
        err_d   = err_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        tctr_d  = tctr_q;
        gap_d   = gap_q;
        rec_err = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mask_d  = test_mask;
                    limit_d = tmo_limit;
                    stop_d  = stop_on_fail;
                    ptr_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    tmo_d   = '0;
                    ferr_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    tctr_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (slot.test_done[cur_q]) begin
                    if (slot.test_fail[cur_q]) begin
                        fail_d  = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
                        rec_err = 1'b1;
                    end else begin
                        pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_W'(1);
                    end
                    state_d = ST_GAP;
                end else if ((limit_q != '0) && (tctr_q == limit_q - TMO_W'(1))) begin
                    tmo_d   = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + CNT_W'(1);
                    rec_err = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    tctr_d = (tctr_q == '1) ? tctr_q : tctr_q + TMO_W'(1);
                end
                if (state_d == ST_GAP) begin
                    gap_d = '0;
                    ptr_d = cur_q + IDX_W'(1);
                end
                // Only the first error of a sequence is recorded.
                if (rec_err && !err_q) begin
                    ferr_d = cur_q;
                    err_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    // Last slot checked explicitly: the scan pointer would wrap at 32 slots.
                    if ((err_q && stop_q) || (cur_q == IDX_W'(NUM_TESTS - 1)))
                        state_d = ST_DONE;
                    else
                        state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from next state so they line up with the state register.
        en_d    = (state_d == ST_RUN) ? (NUM_TESTS'(1) << cur_d) : '0;
        trst_d  = (state_d != ST_RUN);
        busy_d  = (state_d == ST_SELECT) || (state_d == ST_RUN) || (state_d == ST_GAP);
        sdone_d = (state_d == ST_DONE);
        spass_d = (state_d == ST_DONE) && (fail_d == '0) && (tmo_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            limit_q <= '0;
            stop_q  <= 1'b0;
            ptr_q   <= '0;
            cur_q   <= '0;
            ferr_q  <= '0;
            err_q   <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            tmo_q   <= '0;
            tctr_q  <= '0;
            gap_q   <= '0;
            en_q    <= '0;
            trst_q  <= 1'b1;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
            spass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            limit_q <= limit_d;
            stop_q  <= stop_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            ferr_q  <= ferr_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            tctr_q  <= tctr_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            trst_q  <= trst_d;
            busy_q  <= busy_d;
            sdone_q <= sdone_d;
            spass_q <= spass_d;
        end
    end

    assign slot.test_en   = en_q;
    assign slot.test_rst  = trst_q;
    assign busy           = busy_q;
    assign seq_done       = sdone_q;
    assign seq_pass       = spass_q;
    assign cur_idx        = cur_q;
    assign first_err_idx  = ferr_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign tmo_cnt        = tmo_q;
endmodule

// File: tb/tb_pcie_test_seq_ctrl.sv
// Bench for the test sequencer: a 17-slot and a 32-slot instance share stimulus.
// Slots are modelled as counters asserting done a programmed number of enabled cycles later.
// Expected results come from a per-sequence outcome model (slot order, run lengths, totals).
module tb_pcie_test_seq_ctrl;
    import pcie_test_seq_pkg::*;

    localparam int G17 = 16;
    localparam int G32 = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop_on_fail = 1'b0;
    logic [31:0] test_mask = '0;
    logic [31:0] tmo_limit = '0;
    logic        sel = 1'b0;
    logic        noise_on = 1'b0;

    int total = 0;
    int bad = 0;

    pcie_test_seq_ctrl_if #(.NUM_TESTS(17)) sif17 ();
    pcie_test_seq_ctrl_if #(.NUM_TESTS(32)) sif32 ();

    logic             busy17, done17, pass17, busy32, done32, pass32;
    logic [IDX_W-1:0] cur17, ferr17, cur32, ferr32;
    logic [CNT_W-1:0] pc17, fc17, tc17, pc32, fc32, tc32;
    logic             start17, start32;

    assign start17 = start & ~sel;
    assign start32 = start & sel;

    pcie_test_seq_ctrl #(.NUM_TESTS(17), .TMO_W(32), .GAP_CYCLES(G17)) dut17 (
        .clk(clk), .rst(rst), .start(start17), .test_mask(test_mask[16:0]),
        .stop_on_fail(stop_on_fail), .tmo_limit(tmo_limit), .slot(sif17.master),
        .busy(busy17), .seq_done(done17), .seq_pass(pass17), .cur_idx(cur17),
        .first_err_idx(ferr17), .pass_cnt(pc17), .fail_cnt(fc17), .tmo_cnt(tc17)
    );

    pcie_test_seq_ctrl #(.NUM_TESTS(32), .TMO_W(16), .GAP_CYCLES(G32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .test_mask(test_mask),
        .stop_on_fail(stop_on_fail), .tmo_limit(tmo_limit[15:0]), .slot(sif32.master),
        .busy(busy32), .seq_done(done32), .seq_pass(pass32), .cur_idx(cur32),
        .first_err_idx(ferr32), .pass_cnt(pc32), .fail_cnt(fc32), .tmo_cnt(tc32)
    );

    // Observed view of whichever instance is selected.
    logic [31:0]      o_en;
    logic             o_trst, o_busy, o_done, o_spass;
    logic [IDX_W-1:0] o_cur, o_ferr;
    logic [CNT_W-1:0] o_pc, o_fc, o_tc;
    always_comb begin
        o_en    = sel ? sif32.test_en  : {15'b0, sif17.test_en};
        o_trst  = sel ? sif32.test_rst : sif17.test_rst;
        o_busy  = sel ? busy32 : busy17;
        o_done  = sel ? done32 : done17;
        o_spass = sel ? pass32 : pass17;
        o_cur   = sel ? cur32  : cur17;
        o_ferr  = sel ? ferr32 : ferr17;
        o_pc    = sel ? pc32   : pc17;
        o_fc    = sel ? fc32   : fc17;
        o_tc    = sel ? tc32   : tc17;
    end

    // Slot model: lat[i] = enabled cycles before done rises (0 = never done).
    int          lat [32];
    logic [31:0] fcfg = '0;
    int          cnt [32];
    logic [31:0] mdone, done_bus, fail_bus;
    logic [31:0] noise_d = '0, noise_f = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (o_trst) cnt[i] <= 0;
            else if (o_en[i]) cnt[i] <= cnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) mdone[i] = (lat[i] != 0) && (cnt[i] >= lat[i]);
    end

    // Inactive slots carry random junk when noise is on.
    always @(negedge clk) begin
        noise_d <= noise_on ? $urandom : 32'h0;
        noise_f <= noise_on ? $urandom : 32'h0;
    end

    assign done_bus = (o_en & mdone) | (~o_en & noise_d);
    assign fail_bus = (o_en & fcfg)  | (~o_en & noise_f);
    assign sif17.test_done = done_bus[16:0];
    assign sif17.test_fail = fail_bus[16:0];
    assign sif32.test_done = done_bus;
    assign sif32.test_fail = fail_bus;

    // Expected outcome of one sequence.
    int e_slots[$], e_lens[$];
    int e_pass, e_fail, e_tmo, e_first, e_T, e_last;
    // Observed outcome of one sequence.
    int o_slots[$], o_lens[$], o_gaps[$];
    int o_n;

    task automatic model_seq(input int g, input int nt, input logic [31:0] mask,
                             input int limit, input bit stop);
        bit direct = 0;
        bit any_err = 0;
        int len;
        e_slots.delete(); e_lens.delete();
        e_pass = 0; e_fail = 0; e_tmo = 0; e_first = 0; e_last = 0;
        e_T = 1;    // first SELECT cycle after the start edge
        for (int s = 0; s < nt; s++) begin
            if (mask[s]) begin
                bit err_now = 0;
                // Done seen on enabled cycle lat+1; timeout ends the run after limit cycles.
                if (lat[s] != 0 && (limit == 0 || lat[s] + 1 <= limit)) begin
                    len = lat[s] + 1;
                    if (fcfg[s]) begin e_fail++; err_now = 1; end
                    else e_pass++;
                end else begin
                    len = limit;
                    e_tmo++;
                    err_now = 1;
                end
                e_slots.push_back(s);
                e_lens.push_back(len);
                e_last = s;
                e_T += 1 + len + g;   // SELECT + RUN + GAP
                if (err_now && !any_err) begin e_first = s; any_err = 1; end
                if (s == nt - 1 || (stop && any_err)) begin direct = 1; break; end
            end
        end
        if (!direct) e_T += 1;        // final SELECT that finds nothing
    endtask

    task automatic exec_seq(input bit s, input logic [31:0] mask, input int limit,
                            input bit stop, input bit chaos);
        int g, nt, viol, zrun, idx;
        bit timed_out;
        bit ep_ok;
        logic [31:0] prev;
        sel = s;
        nt  = s ? 32 : 17;
        g   = s ? G32 : G17;
        if (!s) mask = mask & 32'h1_FFFF;
        model_seq(g, nt, mask, limit, stop);
        o_slots.delete(); o_lens.delete(); o_gaps.delete();
        viol = 0; zrun = 0; prev = '0; timed_out = 0; o_n = 0;
        @(negedge clk);
        test_mask = mask; tmo_limit = limit; stop_on_fail = stop; start = 1'b1;
        noise_on = chaos;
        forever begin
            @(negedge clk);
            o_n++;
            start = 1'b0;
            if (o_n == 1 && chaos) begin
                test_mask = $urandom; tmo_limit = $urandom_range(1, 5); stop_on_fail = ~stop;
            end
            if (o_done) break;
            if (o_n > 20000) begin timed_out = 1; break; end
            if (!o_busy) viol++;
            if (o_en != 0) begin
                if (((o_en & (o_en - 32'd1)) != 0) || o_trst) viol++;
                if (o_en != prev) begin
                    if (prev != 0) viol++;
                    if (o_slots.size() > 0) o_gaps.push_back(zrun);
                    idx = 0;
                    for (int i = 0; i < 32; i++) if (o_en[i]) idx = i;
                    o_slots.push_back(idx);
                    o_lens.push_back(1);
                end else begin
                    o_lens[o_lens.size() - 1] = o_lens[o_lens.size() - 1] + 1;
                end
                zrun = 0;
            end else begin
                if (!o_trst) viol++;
                zrun++;
            end
            prev = o_en;
            // A start while busy must be ignored.
            if (chaos && o_busy && $urandom_range(0, 15) == 0) start = 1'b1;
        end
        noise_on = 1'b0;

        total++; if (timed_out) begin bad++; $display("FAIL seq_timeout: no seq_done within %0d cycles", o_n); end
        total++; if (o_n != e_T) begin bad++; $display("FAIL done_cycle: got %0d want %0d", o_n, e_T); end
        ep_ok = (o_slots.size() == e_slots.size()) && (o_lens.size() == e_lens.size());
        if (ep_ok) for (int i = 0; i < e_slots.size(); i++)
            if (o_slots[i] != e_slots[i] || o_lens[i] != e_lens[i]) ep_ok = 0;
        total++; if (!ep_ok) begin bad++;
            $display("FAIL episodes: got n=%0d first=%0d/%0d want n=%0d first=%0d/%0d", o_slots.size(),
                     o_slots.size() ? o_slots[0] : -1, o_lens.size() ? o_lens[0] : -1,
                     e_slots.size(), e_slots.size() ? e_slots[0] : -1, e_lens.size() ? e_lens[0] : -1);
        end
        foreach (o_gaps[i]) begin
            total++; if (o_gaps[i] != g + 1) begin bad++; $display("FAIL gap_len[%0d]: got %0d want %0d", i, o_gaps[i], g + 1); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", viol); end
        total++; if (o_pc !== CNT_W'(e_pass)) begin bad++; $display("FAIL pass_cnt: got %0d want %0d", o_pc, e_pass); end
        total++; if (o_fc !== CNT_W'(e_fail)) begin bad++; $display("FAIL fail_cnt: got %0d want %0d", o_fc, e_fail); end
        total++; if (o_tc !== CNT_W'(e_tmo)) begin bad++; $display("FAIL tmo_cnt: got %0d want %0d", o_tc, e_tmo); end
        total++; if (o_ferr !== IDX_W'(e_first)) begin bad++; $display("FAIL first_err_idx: got %0d want %0d", o_ferr, e_first); end
        total++; if (o_spass !== (e_fail == 0 && e_tmo == 0)) begin bad++;
            $display("FAIL seq_pass: got %0d want %0d", o_spass, (e_fail == 0 && e_tmo == 0)); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL busy_in_done: got %0d want 0", o_busy); end
        if (e_slots.size() > 0) begin
            total++; if (o_cur !== IDX_W'(e_last)) begin bad++; $display("FAIL cur_idx: got %0d want %0d", o_cur, e_last); end
        end
        repeat (3) @(negedge clk);
        total++; if (o_done !== 1'b1 || o_pc !== CNT_W'(e_pass)) begin bad++;
            $display("FAIL done_hold: got done=%0d pass=%0d want 1/%0d", o_done, o_pc, e_pass); end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 32; i++) lat[i] = 0;
        fcfg = '0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            total++;
            if (o_en !== 0 || o_trst !== 1 || o_busy !== 0 || o_done !== 0 || o_spass !== 0 ||
                o_cur !== 0 || o_ferr !== 0 || o_pc !== 0 || o_fc !== 0 || o_tc !== 0) begin
                bad++;
                $display("FAIL reset_state[%0d]: got en=%h trst=%0d busy=%0d done=%0d want 0/1/0/0", k, o_en, o_trst, o_busy, o_done);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_two_pass();
        clear_slots();
        lat[0] = 10; lat[2] = 10;
        exec_seq(0, 32'h5, 100, 0, 0);
        total++; if (o_pc !== 2 || o_spass !== 1) begin bad++; $display("FAIL two_pass: got pass=%0d sp=%0d want 2/1", o_pc, o_spass); end
        total++; if (o_slots.size() != 2 || o_slots[0] != 0 || o_slots[1] != 2) begin bad++;
            $display("FAIL two_pass_order: got %0d slots want 0 then 2", o_slots.size()); end
    endtask

    task automatic test_timeout();
        clear_slots();
        lat[0] = 5; lat[2] = 5;
        exec_seq(0, 32'h7, 50, 0, 0);
        total++; if (o_tc !== 1 || o_ferr !== 1 || o_spass !== 0) begin bad++;
            $display("FAIL timeout: got tmo=%0d ferr=%0d sp=%0d want 1/1/0", o_tc, o_ferr, o_spass); end
        total++; if (o_lens.size() != 3 || o_lens[1] != 50) begin bad++;
            $display("FAIL timeout_len: got %0d runs want slot1 run of 50", o_lens.size()); end
    endtask

    task automatic test_stop_on_fail();
        clear_slots();
        lat[0] = 3; lat[1] = 3; lat[2] = 3; fcfg = 32'h1;
        exec_seq(0, 32'h7, 40, 1, 0);
        total++; if (o_fc !== 1 || o_slots.size() != 1) begin bad++;
            $display("FAIL stop_on_fail: got fail=%0d runs=%0d want 1/1", o_fc, o_slots.size()); end
    endtask

    task automatic test_exact_timeout();
        clear_slots();
        lat[0] = 9;                 // done lands on the final timeout cycle
        exec_seq(0, 32'h1, 10, 0, 0);
        total++; if (o_pc !== 1 || o_tc !== 0) begin bad++; $display("FAIL exact_tmo: got pass=%0d tmo=%0d want 1/0", o_pc, o_tc); end
        lat[0] = 10;                // one cycle too late
        exec_seq(0, 32'h1, 10, 0, 0);
        total++; if (o_pc !== 0 || o_tc !== 1) begin bad++; $display("FAIL late_done: got pass=%0d tmo=%0d want 0/1", o_pc, o_tc); end
    endtask

    task automatic test_reset_mid_run();
        int w = 0;
        clear_slots();
        lat[0] = 2; fcfg = 32'h1; lat[1] = 2;
        sel = 1'b0;
        @(negedge clk);
        test_mask = 32'hF; tmo_limit = 20; stop_on_fail = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (o_en !== 32'h8 && w < 500) begin @(negedge clk); w++; end
        total++; if (o_en !== 32'h8) begin bad++; $display("FAIL reach_slot3: got en=%h want 8", o_en); end
        repeat (3) @(negedge clk);
        total++; if (o_pc !== 1 || o_fc !== 1 || o_tc !== 1) begin bad++;
            $display("FAIL pre_reset_cnt: got %0d/%0d/%0d want 1/1/1", o_pc, o_fc, o_tc); end
        rst = 1'b1; start = 1'b1; test_mask = '1;
        @(negedge clk);
        total++;
        if (o_en !== 0 || o_trst !== 1 || o_busy !== 0 || o_done !== 0 || o_spass !== 0 ||
            o_cur !== 0 || o_ferr !== 0 || o_pc !== 0 || o_fc !== 0 || o_tc !== 0) begin
            bad++;
            $display("FAIL mid_run_reset: got en=%h trst=%0d busy=%0d cur=%0d cnt=%0d/%0d/%0d want all clear",
                     o_en, o_trst, o_busy, o_cur, o_pc, o_fc, o_tc);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (o_busy !== 0 || o_trst !== 1) begin bad++; $display("FAIL idle_after_rst: got busy=%0d trst=%0d want 0/1", o_busy, o_trst); end
        fcfg = '0; lat[0] = 3;
        exec_seq(0, 32'h1, 20, 0, 0);
        total++; if (o_slots.size() != 1 || o_slots[0] != 0) begin bad++; $display("FAIL rerun_slot0: got %0d runs want slot 0", o_slots.size()); end
    endtask

    task automatic test_n32();
        clear_slots();
        lat[31] = 4;
        exec_seq(1, 32'h8000_0000, 30, 0, 0);
        total++; if (o_slots.size() != 1 || o_slots[0] != 31) begin bad++; $display("FAIL n32_slot31: got %0d runs want slot 31", o_slots.size()); end
        exec_seq(1, 32'h0, 30, 0, 0);
        total++; if (o_n != 2 || o_spass !== 1 || o_pc !== 0) begin bad++;
            $display("FAIL empty_mask: got cycles=%0d sp=%0d want 2/1", o_n, o_spass); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            bit s;
            int limit;
            logic [31:0] mask;
            s = 1'($urandom_range(0, 1));
            mask = $urandom;
            if ($urandom_range(0, 1) == 1) mask = mask & $urandom;
            limit = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 16);
            for (int i = 0; i < 32; i++) begin
                lat[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 14);
                if (limit == 0 && lat[i] == 0) lat[i] = 1;
            end
            fcfg = $urandom & $urandom;
            exec_seq(s, mask, limit, 1'($urandom_range(0, 1)), 1);
        end
    endtask

    initial begin
        clear_slots();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_pass();
        test_timeout();
        test_stop_on_fail();
        test_exact_timeout();
        test_reset_mid_run();
        test_n32();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcie_test_seq_ctrl.md
PCIE_TEST_SEQ_CTRL -- requirements
Module: pcie_test_seq_ctrl

Interface
REQ-001 Parameter NUM_TESTS, default 17, number of test slots; legal range 1..32.
REQ-002 Parameter TMO_W, default 32, width of timeout counter/limit.
REQ-003 Parameter GAP_CYCLES, default 16, reset-gap cycles between tests; legal range 1..255.
REQ-004 clk  in  1  single clock; one clock, reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a sequence when idle.
REQ-007 test_mask  in  NUM_TESTS  bit i=1 runs slot i; sampled at start.
REQ-008 stop_on_fail  in  1  abort remaining slots after first fail/timeout; sampled at start.
REQ-009 tmo_limit  in  TMO_W  per-test timeout in cycles; sampled at start; 0 disables timeout.
REQ-010 test_done  in  NUM_TESTS  level done from each slot.
REQ-011 test_fail  in  NUM_TESTS  fail flag from each slot, valid when its done is high.
REQ-012 test_en  out  NUM_TESTS  one-hot (or zero) enable of active slot.
REQ-013 test_rst  out  1  active-high reset to slots; low only in RUN.
REQ-014 busy  out  1  high from accepted start until DONE state.
REQ-015 seq_done  out  1  high in DONE until next start or rst.
REQ-016 seq_pass  out  1  valid with seq_done; 1 iff no fail and no timeout.
REQ-017 cur_idx  out  5  index of slot being run/last run.
REQ-018 first_err_idx  out  5  index of first failing/timed-out slot; 0 if none.
REQ-019 pass_cnt, fail_cnt, tmo_cnt  out  6 each  per-sequence result counters.

Function
REQ-020 FSM states IDLE, SELECT, RUN, GAP, DONE; state encoded in shared package enum.
REQ-021 IDLE: start=1 latches mask/limit/stop_on_fail, clears counters and first_err_idx, goes SELECT next cycle; start ignored in any other state except DONE.
REQ-022 DONE: start=1 behaves as in IDLE; otherwise DONE holds.
REQ-023 SELECT: picks lowest-index set bit at or above scan pointer in latched mask (one cycle); found -> RUN with cur_idx updated; none -> DONE.
REQ-024 Empty mask: IDLE->SELECT->DONE, seq_pass=1, counters 0.
REQ-025 RUN: test_en[cur_idx]=1, test_rst=0, timeout counter increments from 0 each cycle.
REQ-026 RUN exit on test_done[cur_idx]=1: fail bit 0 -> pass_cnt+1; fail bit 1 -> fail_cnt+1; go GAP.
REQ-027 RUN exit on counter == tmo_limit-1 with tmo_limit!=0 and done low -> tmo_cnt+1, go GAP.
REQ-028 Done and timeout in same cycle: done wins (counted as pass/fail, not timeout).
REQ-029 First fail or timeout records cur_idx into first_err_idx; later errors do not overwrite.
REQ-030 test_done/test_fail of non-active slots ignored.
REQ-031 GAP: test_en=0, test_rst=1 for exactly GAP_CYCLES cycles; scan pointer = cur_idx+1; then SELECT, or DONE if error occurred and stop_on_fail latched, or cur_idx==NUM_TESTS-1.
REQ-032 Counters saturate at 63; timeout counter saturates at all-ones.
REQ-033 seq_pass = (fail_cnt==0 && tmo_cnt==0), registered, valid in DONE.
REQ-034 All outputs registered; test_en asserts the cycle after RUN entry and deasserts the cycle after RUN exit.

Reset
REQ-035 rst=1 any cycle, including mid-RUN: next state IDLE, test_en=0, test_rst=1, busy=0, seq_done=0, seq_pass=0, cur_idx=0, first_err_idx=0, all counters 0.
REQ-036 Latched config and scan pointer clear on rst; inputs ignored while rst=1.

Structure
REQ-037 Package pcie_test_seq_pkg holds FSM state enum, index width constant (5), counter width constant (6).
REQ-038 One sub-module pcie_test_seq_pick: combinational lowest-set-bit-at-or-above-pointer finder, parameterised on NUM_TESTS.

Verification
REQ-039 Mask=0x00005, limit=100, slots 0 and 2 assert done/pass after 10 cycles -> pass_cnt=2, seq_pass=1, test_en 0x1 then 0x4, 16-cycle test_rst gap.
REQ-040 Mask=0x7, slot 1 never done, limit=50, stop_on_fail=0 -> RUN of slot 1 lasts 50 cycles, tmo_cnt=1, first_err_idx=1, slot 2 still runs, seq_pass=0.
REQ-041 Mask=0x7, slot 0 fails, stop_on_fail=1 -> fail_cnt=1, slots 1-2 never enabled, DONE after one gap.
REQ-042 Slot 0 done asserted on exact timeout cycle -> pass_cnt=1, tmo_cnt=0.
REQ-043 rst pulsed during RUN of slot 3 -> next cycle test_en=0, test_rst=1, all status 0; new start re-runs from slot 0.
REQ-044 NUM_TESTS=32, mask=0x80000000 and mask=0 -> only slot 31 runs; empty mask reaches DONE in 2 cycles with seq_pass=1.
